// File: rtl/conv_interleaver_param.sv
// conv_interleaver_param
// ----------------------
// Parametrised convolutional (Forney) interleaver / deinterleaver.
// A commutator steps through BRANCHES branches, one per accepted symbol.
// In interleave mode (mode=0) branch b delays by b*DEPTH_STEP visits.
// In deinterleave mode (mode=1) branch b delays by (BRANCHES-1-b)*DEPTH_STEP.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   mode       0 = interleave, 1 = deinterleave (registered; a change realigns)
//   in_valid   in_data/in_sync are consumed this cycle
//   in_data    input symbol (WIDTH bits)
//   in_sync    qualified by in_valid: force this symbol onto branch 0
//   out_valid  out_data/out_sync/select are valid
//   out_data   output symbol (zero while its branch is still filling)
//   out_sync   output symbol came from branch 0
//   select     branch index of the output symbol
//   primed     every branch delay line holds real data
//
// Handshake: there is no backpressure. Every cycle with in_valid=1 is consumed.
// out_valid pulses exactly one cycle later, carrying that symbol's result.
// The one exception is a symbol presented on a mode-change cycle: it is dropped.
module conv_interleaver_param #(
    parameter int WIDTH      = 8,
    parameter int BRANCHES   = 12,
    parameter int DEPTH_STEP = 17,
    parameter int SEL_W      = $clog2(BRANCHES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sync,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sync,
    output logic [SEL_W-1:0] select,
    output logic             primed
);
    localparam int C_MAX  = (BRANCHES - 1) * DEPTH_STEP;
    localparam int C_W    = $clog2(C_MAX + 1);
    localparam int TOTAL  = BRANCHES * (BRANCHES - 1) / 2 * DEPTH_STEP;
    localparam int ADDR_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(BRANCHES - 1);

    // Storage is organised by delay slot j (depth j*DEPTH_STEP), not by branch.
    // In deinterleave mode branch b simply uses slot BRANCHES-1-b.
    // As a result one packed buffer serves both modes.
    logic [ADDR_W-1:0] slot_base  [BRANCHES];
    logic [C_W-1:0]    slot_depth [BRANCHES];

    for (genvar g = 0; g < BRANCHES; g++) begin : g_slot
        assign slot_base[g]  = ADDR_W'(DEPTH_STEP * g * (g - 1) / 2);
        assign slot_depth[g] = C_W'(DEPTH_STEP * g);
    end

    logic             mode_q;
    logic [SEL_W-1:0] p;
    logic [C_W-1:0]   c;
    logic [C_W-1:0]   ptr [BRANCHES];
    logic [WIDTH-1:0] mem [TOTAL];

    logic              mode_chg;
    logic              accept;
    logic [SEL_W-1:0]  b_eff;
    logic [SEL_W-1:0]  slot;
    logic [C_W-1:0]    c_eff;
    logic [C_W-1:0]    depth;
    logic [C_W-1:0]    ptr_cur;
    logic [ADDR_W-1:0] addr;
    logic              masked;
    logic [WIDTH-1:0]  sym_out;

    always_comb begin
        mode_chg = (mode != mode_q);
        accept   = in_valid && !mode_chg;
        // A sync symbol is processed as branch 0 with the rotation count cleared.
        b_eff    = in_sync ? '0 : p;
        c_eff    = in_sync ? '0 : c;
        slot     = mode_q ? (LAST - b_eff) : b_eff;
        depth    = slot_depth[slot];
        ptr_cur  = ptr[slot];
        addr     = slot_base[slot] + ADDR_W'(ptr_cur);
        // Fewer completed rotations than the branch delay means the read cell
        // was never written since reset/sync/mode change: emit zero instead.
        masked   = (c_eff < depth);
        sym_out  = '0;
        if (!masked) begin
            if (depth == '0) begin
                sym_out = in_data;
            end else begin
                sym_out = mem[addr];
            end
        end
    end

    assign primed = (c == C_W'(C_MAX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q    <= 1'b0;
            p         <= '0;
            c         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sync  <= 1'b0;
            select    <= '0;
            for (int i = 0; i < BRANCHES; i++) begin
                ptr[i] <= '0;
            end
        end else begin
            mode_q    <= mode;
            out_valid <= accept;
            if (mode_chg) begin
                p <= '0;
                c <= '0;
            end else if (in_valid) begin
                out_data <= sym_out;
                out_sync <= (b_eff == '0);
                select   <= b_eff;
                p        <= (b_eff == LAST) ? '0 : b_eff + 1'b1;
                if (b_eff == LAST && c_eff != C_W'(C_MAX)) begin
                    c <= c_eff + 1'b1;
                end else begin
                    c <= c_eff;
                end
                if (depth != '0) begin
                    ptr[slot] <= (ptr_cur == depth - 1'b1) ? '0 : ptr_cur + 1'b1;
                end
            end
        end
    end

    // Read-before-write: the combinational read above returns the cell written
    // depth visits ago, and the same cell takes the new symbol on this edge.
    always_ff @(posedge clk) begin
        if (accept && depth != '0) begin
            mem[addr] <= in_data;
        end
    end

endmodule
